// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron datapath (Q4.12 data, Q16.24 accumulation).
package neuron_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam int ACC_W  = 40;

    localparam logic [15:0] Q412_MAX = 16'h7FFF;
    localparam logic [15:0] Q412_MIN = 16'h8000;

    typedef logic signed [15:0] q412_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } mac_state_t;

endpackage

// File: rtl/q412_round_sat.sv
// Combinational Q.24 accumulator to Q4.12 conversion: round half up, then saturate.
module q412_round_sat
    import neuron_pkg::*;
#(
    parameter int IN_W       = ACC_W,
    parameter int FRAC_SHIFT = FRAC_W
) (
    input  logic signed [IN_W-1:0] acc_in,
    output logic [15:0]            z_out
);

    localparam logic signed [IN_W:0] HALF =
        {{(IN_W - FRAC_SHIFT + 1){1'b0}}, 1'b1, {(FRAC_SHIFT - 1){1'b0}}};
    localparam logic signed [IN_W:0] MAX_EXT = {{(IN_W - 15){1'b0}}, Q412_MAX};
    localparam logic signed [IN_W:0] MIN_EXT = {{(IN_W - 15){1'b1}}, Q412_MIN};

    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    always_comb begin
        rounded = {acc_in[IN_W-1], acc_in} + HALF;
        shifted = rounded >>> FRAC_SHIFT;
        if (shifted > MAX_EXT) begin
            z_out = Q412_MAX;
        end else if (shifted < MIN_EXT) begin
            z_out = Q412_MIN;
        end else begin
            z_out = shifted[15:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streamed multiply-accumulate producing the rounded, saturated Q4.12 pre-activation.
//
// state | meaning
// IDLE  | waiting for start; bias loaded into acc on start
// ACCUM | accepting (x, w) pairs until N_INPUTS have arrived
// SAT   | round/saturate acc into the z_out register
// OUT   | z_out presented with out_valid until out_ready
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_in,
    input  logic [15:0] w_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] z_out,
    output logic        busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    mac_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [15:0]             z_q, z_d;

    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    q412_t                   z_rs;

    assign prod     = $signed(x_in) * $signed(w_in);
    assign prod_ext = {{(ACC_W - 32){prod[31]}}, prod};
    // Bias is Q4.12; shifting by FRAC_W aligns it with the Q.24 products.
    assign bias_ext = {{(ACC_W - DATA_W - FRAC_W){bias[15]}}, bias, {FRAC_W{1'b0}}};

    q412_round_sat #(
        .IN_W       (ACC_W),
        .FRAC_SHIFT (FRAC_W)
    ) u_round_sat (
        .acc_in (acc_q),
        .z_out  (z_rs)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias_ext;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = acc_q + prod_ext;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = SAT;
                    end
                end
            end
            SAT: begin
                z_d     = z_rs;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign z_out     = z_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: vector table plus flow-control, reset and start-ignore sequences.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z_out;
    logic        busy;

    always #5 clk = ~clk;

    neuron_mac #(.N_INPUTS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0]      b;
        logic [3:0][15:0] x;
        logic [3:0][15:0] w;
        logic [15:0]      z;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] b,
                                input logic [15:0] x0, input logic [15:0] w0,
                                input logic [15:0] x1, input logic [15:0] w1,
                                input logic [15:0] x2, input logic [15:0] w2,
                                input logic [15:0] x3, input logic [15:0] w3,
                                input logic [15:0] z);
        vec_t v;
        v.b = b;
        v.x[0] = x0; v.w[0] = w0;
        v.x[1] = x1; v.w[1] = w1;
        v.x[2] = x2; v.w[2] = w2;
        v.x[3] = x3; v.w[3] = w3;
        v.z = z;
        return v;
    endfunction

    // Result scoreboard: a transfer happens where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h with no expected value queued", z_out);
            end else begin
                chk("z_out", {16'h0, z_out}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_valid(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        // SAT occupies exactly one cycle between the last accept and OUT.
        chk(name, lat, 1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", {31'h0, out_valid}, 0);
        chk("busy_idle", {31'h0, busy}, 0);
        chk("sb_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_op(input vec_t v);
        bias  = v.b;
        start = 1'b1;
        exp_q.push_back(v.z);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x_in     = v.x[i];
            w_in     = v.w[i];
            chk("in_ready_accum", {31'h0, in_ready}, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("out_valid_in_sat", {31'h0, out_valid}, 0);
        wait_valid("latency");
        finish_op();
    endtask

    initial begin
        int pat[7];
        int accepted;

        rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0;
        x_in = '0; w_in = '0; out_ready = 1'b0;

        vecs[0] = mk(16'h0000, 16'h1000, 16'h0800, 16'h1000, 16'h0800,
                     16'h1000, 16'h0800, 16'h1000, 16'h0800, 16'h2000);
        vecs[1] = mk(16'h0000, 16'h7000, 16'h7000, 16'h7000, 16'h7000,
                     16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF);
        vecs[2] = mk(16'h0000, 16'h7000, 16'h9000, 16'h7000, 16'h9000,
                     16'h7000, 16'h9000, 16'h7000, 16'h9000, 16'h8000);
        vecs[3] = mk(16'h0000, 16'h0001, 16'h0800, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0001);
        vecs[4] = mk(16'h0000, 16'h0001, 16'hF800, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0000);
        vecs[5] = mk(16'h0800, 16'h2000, 16'hF000, 16'hF000, 16'hF000,
                     16'h0800, 16'h0800, 16'h0000, 16'h1234, 16'hFC00);
        vecs[6] = mk(16'h7FFF, 16'h0001, 16'h1000, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF);
        vecs[7] = mk(16'h0000, 16'hFFFF, 16'h1800, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF);
        vecs[8] = mk(16'h8000, 16'hFFFF, 16'h1000, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h8000);
        vecs[9] = mk(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h1000);

        tick();
        tick();
        chk("rst_z_out", {16'h0, z_out}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'h0, busy}, 0);

        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v]);
        end

        // Flow control: gapped in_valid, garbage on idle slots, long back-pressure in OUT.
        pat = '{1, 0, 0, 1, 1, 0, 1};
        accepted = 0;
        bias  = 16'h0100;
        start = 1'b1;
        exp_q.push_back(16'h1100);
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (pat[i] != 0);
            x_in = in_valid ? 16'h1000 : 16'h7000;
            w_in = in_valid ? 16'h0400 : 16'h7000;
            if (in_valid && in_ready) accepted++;
            tick();
        end
        in_valid = 1'b1;
        x_in = 16'h7000;
        w_in = 16'h7000;
        chk("fc_in_ready_sat", {31'h0, in_ready}, 0);
        wait_valid("fc_latency");
        for (int i = 0; i < 5; i++) begin
            chk("fc_out_valid_hold", {31'h0, out_valid}, 1);
            chk("fc_z_hold", {16'h0, z_out}, 32'h1100);
            chk("fc_in_ready_out", {31'h0, in_ready}, 0);
            if (in_valid && in_ready) accepted++;
            tick();
        end
        chk("fc_accepted", accepted, 4);
        in_valid = 1'b0;
        finish_op();

        // Reset mid-operation discards the partial sum and clears the held result.
        bias  = 16'h3000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x_in = 16'h1000;
            w_in = 16'h1000;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_z_out", {16'h0, z_out}, 0);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
        run_op(vecs[9]);

        // start held through ACCUM and OUT must not restart the operation.
        bias  = 16'hF000;
        start = 1'b1;
        exp_q.push_back(16'hF000);
        tick();
        bias = 16'h7000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x_in = 16'h0;
            w_in = 16'h0;
            tick();
        end
        in_valid = 1'b0;
        chk("si_in_ready_sat", {31'h0, in_ready}, 0);
        wait_valid("si_latency");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("si_busy_after_out", {31'h0, busy}, 0);
        chk("si_in_ready_idle", {31'h0, in_ready}, 0);
        start = 1'b0;
        tick();
        chk("si_busy_idle", {31'h0, busy}, 0);
        chk("si_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
